// File: rtl/trig_buffer_alloc.sv
// Trigger buffer allocator: hands out SURF buffer indices to triggers in
// ring order, retires them as completed events land in RAM, flags
// dead-time when the ring is (nearly) full, and keeps per-PPS-second
// occupancy statistics.
module trig_buffer_alloc #(
  parameter int NBUF        = 4,
  parameter int DEAD_MARGIN = 0,
  parameter int OCC_WIDTH   = 32,
  localparam int IDXW       = $clog2(NBUF),
  localparam int CNTW       = IDXW + 1
) (
  input  logic                 sys_clk_i,
  input  logic                 sys_rst_n_i,
  input  logic                 pps_i,
  input  logic                 runrst_i,
  input  logic                 runstop_i,
  input  logic                 trig_i,
  output logic [IDXW-1:0]      trig_buf_o,
  input  logic                 last_flag_i,
  input  logic [IDXW-1:0]      last_buf_i,
  output logic                 dead_o,
  output logic [CNTW-1:0]      count_o,
  output logic [OCC_WIDTH-1:0] occupancy_o,
  output logic [CNTW-1:0]      max_occ_o,
  output logic                 surf_err_o,
  output logic                 turf_err_o,
  output logic                 order_err_o
);

  localparam logic [CNTW-1:0] FULL    = CNTW'(NBUF);
  localparam logic [CNTW-1:0] DEAD_TH = CNTW'(NBUF - DEAD_MARGIN);
  localparam int              ACCW    = OCC_WIDTH + 1;

  logic [IDXW-1:0]      wr_ptr, wr_ptr_n;
  logic [IDXW-1:0]      rd_ptr, rd_ptr_n;
  logic [CNTW-1:0]      count, count_n;
  logic                 running, running_n;
  logic                 surf_err_n, turf_err_n, order_err_n;
  logic                 trig_ok, done_ok;
  logic [OCC_WIDTH-1:0] acc;
  logic [ACCW-1:0]      acc_sum;
  logic [CNTW-1:0]      peak;

  assign trig_buf_o = wr_ptr;
  assign count_o    = count;

  // Acceptance is judged against the count held at the start of the cycle.
  assign trig_ok = trig_i && (count != FULL);
  assign done_ok = last_flag_i && (count != '0);

  // Next-state for pointers, count, running and sticky error flags.
  always_comb begin
    wr_ptr_n    = wr_ptr;
    rd_ptr_n    = rd_ptr;
    count_n     = count;
    running_n   = running;
    surf_err_n  = surf_err_o;
    turf_err_n  = turf_err_o;
    order_err_n = order_err_o;
    if (runrst_i) begin
      wr_ptr_n    = '0;
      rd_ptr_n    = '0;
      count_n     = '0;
      running_n   = 1'b1;
      surf_err_n  = 1'b0;
      turf_err_n  = 1'b0;
      order_err_n = 1'b0;
    end else begin
      if (runstop_i) begin
        running_n = 1'b0;
      end
      if (trig_ok) begin
        wr_ptr_n = wr_ptr + IDXW'(1);
      end
      if (done_ok) begin
        rd_ptr_n = rd_ptr + IDXW'(1);
      end
      if (trig_ok && !done_ok) begin
        count_n = count + CNTW'(1);
      end else if (done_ok && !trig_ok) begin
        count_n = count - CNTW'(1);
      end
      if (running && trig_i && !trig_ok) begin
        turf_err_n = 1'b1;
      end
      if (running && last_flag_i && !done_ok) begin
        surf_err_n = 1'b1;
      end
      if (running && done_ok && (last_buf_i != rd_ptr)) begin
        order_err_n = 1'b1;
      end
    end
  end

  // Tracking state register; dead_o is built from next-state so it lines up with count_o.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      running     <= 1'b0;
      dead_o      <= 1'b0;
      surf_err_o  <= 1'b0;
      turf_err_o  <= 1'b0;
      order_err_o <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      count       <= count_n;
      running     <= running_n;
      dead_o      <= (count_n >= DEAD_TH) && running_n;
      surf_err_o  <= surf_err_n;
      turf_err_o  <= turf_err_n;
      order_err_o <= order_err_n;
    end
  end

  assign acc_sum = {1'b0, acc} + ACCW'(count);

  // Per-second occupancy integral and peak; independent of running and runrst.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      acc         <= '0;
      peak        <= '0;
      occupancy_o <= '0;
      max_occ_o   <= '0;
    end else if (pps_i) begin
      occupancy_o <= acc;
      acc         <= OCC_WIDTH'(count);
      max_occ_o   <= peak;
      peak        <= count;
    end else begin
      acc  <= acc_sum[OCC_WIDTH] ? {OCC_WIDTH{1'b1}} : acc_sum[OCC_WIDTH-1:0];
      peak <= (count > peak) ? count : peak;
    end
  end

endmodule

// File: tb/tb_trig_buffer_alloc.sv
// Directed bench for trig_buffer_alloc. Two instances share one stimulus
// stream: dut_a uses defaults, dut_b uses DEAD_MARGIN=1 and an 8-bit
// occupancy accumulator so dead-margin and saturation behaviour can be
// checked against the same event history.
module tb_trig_buffer_alloc;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       pps       = 1'b0;
  logic       runrst    = 1'b0;
  logic       runstop   = 1'b0;
  logic       trig      = 1'b0;
  logic       last_flag = 1'b0;
  logic [1:0] last_buf  = 2'd0;

  logic [1:0]  a_trig_buf, b_trig_buf;
  logic        a_dead, b_dead;
  logic [2:0]  a_count, b_count;
  logic [31:0] a_occ;
  logic [7:0]  b_occ;
  logic [2:0]  a_max, b_max;
  logic        a_surf, a_turf, a_order;
  logic        b_surf, b_turf, b_order;

  int compared   = 0;
  int mismatched = 0;

  trig_buffer_alloc #(.NBUF(4), .DEAD_MARGIN(0), .OCC_WIDTH(32)) dut_a (
    .sys_clk_i(sys_clk), .sys_rst_n_i(sys_rst_n), .pps_i(pps),
    .runrst_i(runrst), .runstop_i(runstop), .trig_i(trig),
    .trig_buf_o(a_trig_buf), .last_flag_i(last_flag), .last_buf_i(last_buf),
    .dead_o(a_dead), .count_o(a_count), .occupancy_o(a_occ), .max_occ_o(a_max),
    .surf_err_o(a_surf), .turf_err_o(a_turf), .order_err_o(a_order)
  );

  trig_buffer_alloc #(.NBUF(4), .DEAD_MARGIN(1), .OCC_WIDTH(8)) dut_b (
    .sys_clk_i(sys_clk), .sys_rst_n_i(sys_rst_n), .pps_i(pps),
    .runrst_i(runrst), .runstop_i(runstop), .trig_i(trig),
    .trig_buf_o(b_trig_buf), .last_flag_i(last_flag), .last_buf_i(last_buf),
    .dead_o(b_dead), .count_o(b_count), .occupancy_o(b_occ), .max_occ_o(b_max),
    .surf_err_o(b_surf), .turf_err_o(b_turf), .order_err_o(b_order)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drives one cycle of inputs, steps past the edge, then idles the inputs.
  task automatic applyStimulus(input logic t, input logic l, input logic [1:0] lb,
                               input logic rr, input logic rs, input logic p);
    trig = t; last_flag = l; last_buf = lb; runrst = rr; runstop = rs; pps = p;
    @(posedge sys_clk);
    #1;
    trig = 1'b0; last_flag = 1'b0; last_buf = 2'd0;
    runrst = 1'b0; runstop = 1'b0; pps = 1'b0;
  endtask

  task automatic checkErrors(input string tag, input logic s, input logic t, input logic o);
    checkOutput({tag, "_surf"},  32'(a_surf),  32'(s));
    checkOutput({tag, "_turf"},  32'(a_turf),  32'(t));
    checkOutput({tag, "_order"}, 32'(a_order), 32'(o));
  endtask

  initial begin
    // Asynchronous reset with no clock edge in between.
    #2 sys_rst_n = 1'b0;
    #1;
    checkOutput("rst_count", 32'(a_count), 0);
    checkOutput("rst_dead", 32'(a_dead), 0);
    checkOutput("rst_occ", a_occ, 0);
    checkOutput("rst_max", 32'(a_max), 0);
    checkErrors("rst", 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // Fill the ring from a fresh run.
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("runrst_count", 32'(a_count), 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("trig_buf_%0d", i), 32'(a_trig_buf), 32'(i));
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput($sformatf("fill_count_%0d", i), 32'(a_count), 32'(i + 1));
      if (i == 2) begin
        checkOutput("a_dead_at3", 32'(a_dead), 0);
        checkOutput("b_dead_rise3", 32'(b_dead), 1);
      end
    end
    checkOutput("a_dead_at4", 32'(a_dead), 1);
    checkErrors("full", 1'b0, 1'b0, 1'b0);

    // Trigger into a full ring is rejected.
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("overflow_count", 32'(a_count), 4);
    checkOutput("overflow_wrptr", 32'(a_trig_buf), 0);
    checkErrors("overflow", 1'b0, 1'b1, 1'b0);

    // Both at full: trigger rejected, completion of buffer 0 accepted.
    applyStimulus(1, 1, 2'd0, 0, 0, 0);
    checkOutput("both_full_count", 32'(a_count), 3);
    checkOutput("both_full_wrptr", 32'(a_trig_buf), 0);
    checkErrors("both_full", 1'b0, 1'b1, 1'b0);
    checkOutput("a_dead_fall3", 32'(a_dead), 0);
    checkOutput("b_dead_hold3", 32'(b_dead), 1);

    // rd_ptr must now be 1: completing buffer 1 is in order.
    applyStimulus(0, 1, 2'd1, 0, 0, 0);
    checkOutput("retire1_count", 32'(a_count), 2);
    checkOutput("retire1_order", 32'(a_order), 0);
    checkOutput("b_dead_fall2", 32'(b_dead), 0);

    // Run reset clears errors and tracking.
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("rr1_count", 32'(a_count), 0);
    checkErrors("rr1", 1'b0, 1'b0, 1'b0);

    // Out-of-order completion still retires.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("ooo_pre_count", 32'(a_count), 2);
    applyStimulus(0, 1, 2'd1, 0, 0, 0);
    checkOutput("ooo_count", 32'(a_count), 1);
    checkErrors("ooo", 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("rr2_count", 32'(a_count), 0);
    checkErrors("rr2", 1'b0, 1'b0, 1'b0);

    // Both at empty: completion rejected, trigger accepted.
    applyStimulus(1, 1, 2'd0, 0, 0, 0);
    checkOutput("both_empty_count", 32'(a_count), 1);
    checkOutput("both_empty_wrptr", 32'(a_trig_buf), 1);
    checkErrors("both_empty", 1'b1, 1'b0, 1'b0);

    // Underflow while running, then the same after runstop.
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 2'd0, 0, 0, 0);
    checkErrors("underflow_run", 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 2'd0, 0, 0, 0);
    checkErrors("underflow_stop", 1'b0, 1'b0, 1'b0);
    checkOutput("underflow_stop_count", 32'(a_count), 0);

    // Occupancy over one PPS second with count held at 2.
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 999; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("occ_a", a_occ, 2000);
    checkOutput("max_a", 32'(a_max), 2);
    checkOutput("occ_b_sat", 32'(b_occ), 255);
    checkOutput("max_b", 32'(b_max), 2);

    // Reset mid-run drops held buffers silently; first edge after release counts.
    #2 sys_rst_n = 1'b0;
    #1;
    checkOutput("midrst_count", 32'(a_count), 0);
    checkOutput("midrst_occ", a_occ, 0);
    checkErrors("midrst", 1'b0, 1'b0, 1'b0);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("post_rst_count", 32'(a_count), 1);
    checkOutput("post_rst_dead", 32'(a_dead), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/trig_buffer_alloc.md
TRIG_BUFFER_ALLOC -- requirements
Module: trig_buffer_alloc

Interface
REQ-001 SHALL have parameter NBUF, default 4: number of SURF buffers tracked; power of two, 2..16.
REQ-002 SHALL have parameter DEAD_MARGIN, default 0: dead threshold is NBUF-DEAD_MARGIN; legal range 0..NBUF-1.
REQ-003 SHALL have parameter OCC_WIDTH, default 32: occupancy accumulator width.
REQ-004 SHALL define IDXW = clog2(NBUF) and CNTW = IDXW+1, derived and not overridable.
REQ-005 SHALL use one clock and an asynchronous active-low reset, ports as follows.
REQ-006 sys_clk_i  in  1  sole clock; all logic rising-edge.
REQ-007 sys_rst_n_i  in  1  asynchronous active-low reset.
REQ-008 pps_i  in  1  one-cycle PPS strobe, sys_clk_i domain.
REQ-009 runrst_i  in  1  run reset: clears tracking and errors, sets running.
REQ-010 runstop_i  in  1  run stop: clears running.
REQ-011 trig_i  in  1  trigger issued by master trigger process.
REQ-012 trig_buf_o  out  IDXW  buffer index assigned to the trigger in the current cycle.
REQ-013 last_flag_i  in  1  event complete and in RAM.
REQ-014 last_buf_i  in  IDXW  buffer index of the completed event.
REQ-015 dead_o  out  1  no more triggers.
REQ-016 count_o  out  CNTW  buffers currently held.
REQ-017 occupancy_o  out  OCC_WIDTH  sum of count over the previous PPS second.
REQ-018 max_occ_o  out  CNTW  peak count over the previous PPS second.
REQ-019 surf_err_o / turf_err_o / order_err_o  out  1 each  sticky error flags.

Function
REQ-020 running SHALL be set by runrst_i and cleared by runstop_i; runrst_i wins if both are high.
REQ-021 State SHALL be wr_ptr and rd_ptr (IDXW bits each, wrap modulo NBUF) plus count (0..NBUF); trig_buf_o SHALL equal wr_ptr combinationally.
REQ-022 A trigger SHALL be accepted when trig_i=1 and count<NBUF: wr_ptr advances by 1.
REQ-023 trig_i=1 with count==NBUF SHALL be rejected: wr_ptr and count unchanged; turf_err set if running.
REQ-024 A completion SHALL be accepted when last_flag_i=1 and count>0: rd_ptr advances by 1.
REQ-025 last_flag_i=1 with count==0 SHALL be rejected with no state change; surf_err set if running.
REQ-026 An accepted completion with last_buf_i!=rd_ptr SHALL set order_err if running, and still retire (rd_ptr advances).
REQ-027 Acceptance of each event SHALL be judged against the count at the start of the cycle.
REQ-028 Both events accepted in one cycle: count unchanged, both pointers advance.
REQ-029 Both events at count==NBUF: trigger rejected, completion accepted, next count NBUF-1.
REQ-030 Both events at count==0: completion rejected, trigger accepted, next count 1.
REQ-031 count_o SHALL be registered and track count with one-cycle latency from the event edge.
REQ-032 dead_o SHALL be registered from next-state values: dead_o = (next count >= NBUF-DEAD_MARGIN) AND next running, so it is coincident with count_o.
REQ-033 Accumulator: on non-PPS cycles, acc += count, saturating at all-ones.
REQ-034 On a pps_i cycle: occupancy_o <= acc; acc <= count.
REQ-035 Peak tracking: on non-PPS cycles, peak <= max(peak, count).
REQ-036 On a pps_i cycle: max_occ_o <= peak; peak <= count.
REQ-037 Accumulation and peak tracking SHALL run regardless of running.
REQ-038 Error flags SHALL be registered and sticky until runrst_i or reset.
REQ-039 runrst_i SHALL synchronously clear pointers, count and errors; trig_i/last_flag_i in that cycle are ignored; acc, peak, occupancy_o and max_occ_o are unaffected.

Reset
REQ-040 sys_rst_n_i low SHALL asynchronously clear wr_ptr, rd_ptr, count, running, dead_o, acc, peak, occupancy_o, max_occ_o and all error flags to 0.
REQ-041 Release SHALL be synchronous to sys_clk_i; the first event is honoured on the first edge after release.
REQ-042 Reset asserted mid-run SHALL discard held buffers with no error raised.

Verification
REQ-043 NBUF=4, runrst, 4 trig -> trig_buf_o 0,1,2,3; count_o=4; dead_o=1 in the same cycle count_o=4; fifth trig -> turf_err_o=1, count_o stays 4.
REQ-044 count=4, trig+last (last_buf_i=0) together -> count_o=3, turf_err_o=1, order_err_o=0, rd_ptr=1.
REQ-045 count=0, running, last_flag_i -> surf_err_o=1; same stimulus after runstop -> no error.
REQ-046 count=2, rd_ptr=0, last_buf_i=1 -> order_err_o=1, count_o=1; runrst -> all errors 0, count_o=0.
REQ-047 DEAD_MARGIN=1, NBUF=4: dead_o rises at count_o=3 and falls at count_o=2.
REQ-048 count held at 2 for 1000 cycles between PPS -> occupancy_o=2000, max_occ_o=2; saturation check with OCC_WIDTH=8 -> occupancy_o=255.
